yukle_sakla_birimi: RTL and testbench

YUKLE_SAKLA_BIRIMI -- requirements
Module: yukle_sakla_birimi

---
 rtl/yukle_sakla_birimi.sv | 179 +++++++++++++++++
 tb/tb_yukle_sakla_birimi.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/yukle_sakla_birimi.sv
// Load/store unit between a core request port and a single-cycle word memory.
// Handles byte/halfword/word accesses, sign extension, read-modify-write stores and misalignment.
module yukle_sakla_birimi (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        istek_i,
    input  logic        yaz_i,
    input  logic [1:0]  boyut_i,
    input  logic        isaretsiz_i,
    input  logic [31:0] adres_i,
    input  logic [31:0] veri_i,
    output logic        hazir_o,
    output logic        gecerli_o,
    output logic        hata_o,
    output logic [31:0] veri_o,
    output logic        bel_wen_o,
    output logic [31:0] bel_adres_o,
    output logic [31:0] bel_veri_o,
    input  logic [31:0] bel_veri_i
);

    typedef enum logic [1:0] {
        BOSTA = 2'b00,
        OKU   = 2'b01,
        YAZ   = 2'b10
    } durum_t;

    durum_t      durum_r, durum_s;
    logic        yaz_r, yaz_s;
    logic [1:0]  boyut_r, boyut_s;
    logic        isaretsiz_r, isaretsiz_s;
    logic [31:0] adres_r, adres_s;
    logic [31:0] veri_r, veri_s;
    logic        gecerli_r, gecerli_s;
    logic        hata_r, hata_s;
    logic [31:0] cikis_r, cikis_s;

    function automatic logic hizasiz(input logic [1:0] boyut, input logic [1:0] ofs);
        logic sonuc;
        case (boyut)
            2'b00:   sonuc = 1'b0;
            2'b01:   sonuc = ofs[0];
            2'b10:   sonuc = (ofs != 2'b00);
            default: sonuc = 1'b1;
        endcase
        return sonuc;
    endfunction

    function automatic logic [31:0] genislet(input logic [31:0] kelime, input logic [1:0] boyut,
                                             input logic isaretsiz, input logic [1:0] ofs);
        logic [31:0] kayik;
        logic [31:0] sonuc;
        kayik = kelime >> {ofs, 3'b000};
        case (boyut)
            2'b00:   sonuc = {{24{~isaretsiz & kayik[7]}}, kayik[7:0]};
            2'b01:   sonuc = {{16{~isaretsiz & kayik[15]}}, kayik[15:0]};
            default: sonuc = kelime;
        endcase
        return sonuc;
    endfunction

    // Only the addressed lanes are replaced; the rest of the word is written back unchanged.
    function automatic logic [31:0] birlestir(input logic [31:0] eski, input logic [31:0] yeni,
                                              input logic [1:0] boyut, input logic [1:0] ofs);
        logic [31:0] maske;
        case (boyut)
            2'b00:   maske = 32'h0000_00FF;
            2'b01:   maske = 32'h0000_FFFF;
            default: maske = 32'hFFFF_FFFF;
        endcase
        maske = maske << {ofs, 3'b000};
        return (eski & ~maske) | ((yeni << {ofs, 3'b000}) & maske);
    endfunction

    // Memory-side outputs follow the state directly so an async reset removes them at once.
    always_comb begin
        hazir_o     = (durum_r == BOSTA);
        bel_wen_o   = (durum_r == YAZ);
        bel_adres_o = 32'h0000_0000;
        bel_veri_o  = 32'h0000_0000;
        if (durum_r != BOSTA) begin
            bel_adres_o = {adres_r[31:2], 2'b00};
        end else begin
            bel_adres_o = 32'h0000_0000;
        end
        if (durum_r == YAZ) begin
            bel_veri_o = birlestir(bel_veri_i, veri_r, boyut_r, adres_r[1:0]);
        end else begin
            bel_veri_o = 32'h0000_0000;
        end
    end

    // Next-state and next-response logic.
    always_comb begin
        durum_s     = durum_r;
        yaz_s       = yaz_r;
        boyut_s     = boyut_r;
        isaretsiz_s = isaretsiz_r;
        adres_s     = adres_r;
        veri_s      = veri_r;
        gecerli_s   = 1'b0;
        hata_s      = 1'b0;
        cikis_s     = 32'h0000_0000;
        case (durum_r)
            BOSTA: begin
                if (istek_i) begin
                    yaz_s       = yaz_i;
                    boyut_s     = boyut_i;
                    isaretsiz_s = isaretsiz_i;
                    adres_s     = adres_i;
                    veri_s      = veri_i;
                    if (hizasiz(boyut_i, adres_i[1:0])) begin
                        gecerli_s = 1'b1;
                        hata_s    = 1'b1;
                    end else if (yaz_i) begin
                        durum_s = YAZ;
                    end else begin
                        durum_s = OKU;
                    end
                end else begin
                    durum_s = BOSTA;
                end
            end
            OKU: begin
                cikis_s   = genislet(bel_veri_i, boyut_r, isaretsiz_r, adres_r[1:0]);
                gecerli_s = 1'b1;
                durum_s   = BOSTA;
            end
            YAZ: begin
                gecerli_s = 1'b1;
                durum_s   = BOSTA;
            end
            default: begin
                durum_s = BOSTA;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_r <= BOSTA;
        end else begin
            durum_r <= durum_s;
        end
    end

    // Request capture and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            yaz_r       <= 1'b0;
            boyut_r     <= 2'b00;
            isaretsiz_r <= 1'b0;
            adres_r     <= 32'h0000_0000;
            veri_r      <= 32'h0000_0000;
            gecerli_r   <= 1'b0;
            hata_r      <= 1'b0;
            cikis_r     <= 32'h0000_0000;
        end else begin
            yaz_r       <= yaz_s;
            boyut_r     <= boyut_s;
            isaretsiz_r <= isaretsiz_s;
            adres_r     <= adres_s;
            veri_r      <= veri_s;
            gecerli_r   <= gecerli_s;
            hata_r      <= hata_s;
            cikis_r     <= cikis_s;
        end
    end

    assign gecerli_o = gecerli_r;
    assign hata_o    = hata_r;
    assign veri_o    = cikis_r;

    // The direction flag is kept for visibility; the state already encodes it.
    logic kullanilmayan;
    assign kullanilmayan = yaz_r;

endmodule

// File: tb/tb_yukle_sakla_birimi.sv
// Directed self-checking bench for yukle_sakla_birimi with a small behavioural word memory.
module tb_yukle_sakla_birimi;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        istek_i;
    logic        yaz_i;
    logic [1:0]  boyut_i;
    logic        isaretsiz_i;
    logic [31:0] adres_i;
    logic [31:0] veri_i;
    logic        hazir_o;
    logic        gecerli_o;
    logic        hata_o;
    logic [31:0] veri_o;
    logic        bel_wen_o;
    logic [31:0] bel_adres_o;
    logic [31:0] bel_veri_o;
    logic [31:0] bel_veri_i;

    logic [31:0] mem [0:63];
    logic        tb_we = 1'b0;
    logic [5:0]  tb_idx = 6'd0;
    logic [31:0] tb_wd = 32'h0;

    int n_check = 0;
    int n_pass  = 0;
    logic [31:0] yakalanan;

    yukle_sakla_birimi dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .istek_i     (istek_i),
        .yaz_i       (yaz_i),
        .boyut_i     (boyut_i),
        .isaretsiz_i (isaretsiz_i),
        .adres_i     (adres_i),
        .veri_i      (veri_i),
        .hazir_o     (hazir_o),
        .gecerli_o   (gecerli_o),
        .hata_o      (hata_o),
        .veri_o      (veri_o),
        .bel_wen_o   (bel_wen_o),
        .bel_adres_o (bel_adres_o),
        .bel_veri_o  (bel_veri_o),
        .bel_veri_i  (bel_veri_i)
    );

    always #5 clk_i = ~clk_i;

    assign bel_veri_i = mem[bel_adres_o[7:2]];

    always @(posedge clk_i) begin
        if (tb_we) mem[tb_idx] <= tb_wd;
        else if (bel_wen_o) mem[bel_adres_o[7:2]] <= bel_veri_o;
    end

    task automatic kontrol_et(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_check++;
        if (gozlenen === beklenen) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
    endtask

    task automatic mem_yaz(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk_i);
        tb_we = 1'b1; tb_idx = idx; tb_wd = d;
        @(posedge clk_i); #1;
        tb_we = 1'b0;
    endtask

    // One request; checks latency, pulse width, error flag, data and write-enable count.
    task automatic islem(input string etiket, input logic y, input logic [1:0] b, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic bek_hata, input logic [31:0] bek_veri);
        int wen_say;
        wen_say = 0;
        @(negedge clk_i);
        istek_i = 1'b1; yaz_i = y; boyut_i = b; isaretsiz_i = u; adres_i = a; veri_i = d;
        kontrol_et({etiket, "_hazir"}, {31'd0, hazir_o}, 32'd1);
        @(posedge clk_i); #1;
        istek_i = 1'b0;
        if (bel_wen_o) begin
            wen_say++;
            yakalanan = bel_veri_o;
        end
        if (!bek_hata) begin
            kontrol_et({etiket, "_erken"}, {31'd0, gecerli_o}, 32'd0);
            @(posedge clk_i); #1;
            if (bel_wen_o) wen_say++;
        end
        kontrol_et({etiket, "_gecerli"}, {31'd0, gecerli_o}, 32'd1);
        kontrol_et({etiket, "_hata"}, {31'd0, hata_o}, {31'd0, bek_hata});
        kontrol_et({etiket, "_veri"}, veri_o, bek_veri);
        kontrol_et({etiket, "_hazir2"}, {31'd0, hazir_o}, 32'd1);
        kontrol_et({etiket, "_wen"}, wen_say, (y && !bek_hata) ? 32'd1 : 32'd0);
        @(posedge clk_i); #1;
        kontrol_et({etiket, "_darbe"}, {31'd0, gecerli_o}, 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; istek_i = 1'b0; yaz_i = 1'b0; boyut_i = 2'b00; isaretsiz_i = 1'b0;
        adres_i = 32'h0; veri_i = 32'h0; yakalanan = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        kontrol_et("rst_hazir", {31'd0, hazir_o}, 32'd1);
        kontrol_et("rst_gecerli", {31'd0, gecerli_o}, 32'd0);
        kontrol_et("rst_veri", veri_o, 32'h0);
        kontrol_et("rst_wen", {31'd0, bel_wen_o}, 32'd0);
        kontrol_et("rst_adres", bel_adres_o, 32'h0);
        kontrol_et("rst_belveri", bel_veri_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        mem_yaz(6'd4, 32'h8877_6655);
        mem_yaz(6'd8, 32'h1122_3344);

        islem("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF88);
        islem("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000_8877);
        islem("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8877_6655);
        islem("lbu_10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_0055);
        islem("lh_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_8877);
        islem("lb_11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_0066);

        // Back-to-back word loads with the request held high.
        @(negedge clk_i);
        istek_i = 1'b1; yaz_i = 1'b0; boyut_i = 2'b10; isaretsiz_i = 1'b0; adres_i = 32'h10;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            kontrol_et("b2b_gecerli", {31'd0, gecerli_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) kontrol_et("b2b_veri", veri_o, 32'h8877_6655);
        end
        istek_i = 1'b0;
        @(posedge clk_i); #1;
        kontrol_et("b2b_son", {31'd0, gecerli_o}, 32'd0);

        islem("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, 32'h0);
        kontrol_et("sb_11_belveri", yakalanan, 32'h8877_AB55);
        islem("lw_sb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8877_AB55);
        islem("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, 1'b0, 32'h0);
        kontrol_et("sh_12_belveri", yakalanan, 32'h1234_AB55);
        islem("lw_sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_AB55);

        islem("hiza_lw12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0);
        islem("hiza_lh11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0);
        islem("hiza_sw11", 1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b1, 32'h0);
        kontrol_et("hiza_mem", mem[4], 32'h1234_AB55);

        // Reset asserted while the store word sits in YAZ.
        @(negedge clk_i);
        istek_i = 1'b1; yaz_i = 1'b1; boyut_i = 2'b10; adres_i = 32'h20; veri_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        istek_i = 1'b0;
        kontrol_et("yaz_wen", {31'd0, bel_wen_o}, 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        kontrol_et("rstyaz_wen", {31'd0, bel_wen_o}, 32'd0);
        kontrol_et("rstyaz_adres", bel_adres_o, 32'h0);
        kontrol_et("rstyaz_belveri", bel_veri_o, 32'h0);
        @(posedge clk_i); #1;
        kontrol_et("rstyaz_mem", mem[8], 32'h1122_3344);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        kontrol_et("rstyaz_gecerli", {31'd0, gecerli_o}, 32'd0);
        kontrol_et("rstyaz_hazir", {31'd0, hazir_o}, 32'd1);
        islem("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1122_3344);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
